decoder_scan_driver: RTL and testbench
======================================

# decoder_scan_driver

Sequential select generator that feeds a 74x138-style 3-to-8 decoder. It steps a 3-bit select through 0..LAST_INDEX and drives the decoder's three enables, with a programmable dwell per select and a blanking gap between selects to prevent ghosting. Typical use is scanning display digits or a LED row: this block sits directly upstream of the decoder, and its outputs connect one-to-one to the decoder's C/B/A, G, G_2A and G_2B pins.

## Interface
- DIV_WIDTH, 16: width of the dwell prescaler counter.
- DIV_MAX, 3: SCAN dwell is DIV_MAX+1 cycles; must fit in DIV_WIDTH bits.
- BLANK_CYCLES, 1: BLANK gap in cycles; legal range 1..15.
- LAST_INDEX, 7: last select value before wrap to 0; legal range 0..7.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = free-running scan, 0 = idle.
- step  in  1  single-cycle pulse; advances select while idle. Present only with SCAN_STEP_EN.
- sel  out  3  decoder select {C,B,A}.
- g1  out  1  decoder G, active-high enable.
- g2a_n  out  1  decoder G_2A, active-low enable.
- g2b_n  out  1  decoder G_2B, active-low enable.
- frame_done  out  1  one-cycle pulse when sel wraps from LAST_INDEX to 0.

## Operation
- All outputs are registered.
- Reset values:
  - state = IDLE; sel = 0; prescaler = 0; blank counter = 0.
  - g1 = 0, g2a_n = 1, g2b_n = 1: decoder disabled, all Y outputs high.
  - frame_done = 0.
- States:
  - IDLE: decoder disabled.
  - SCAN: g1 = 1, g2a_n = 0, g2b_n = 0.
  - BLANK: decoder disabled.
- IDLE, run = 1: clear sel, prescaler and blank counter to 0, then go to SCAN.
- SCAN: prescaler increments each cycle. When prescaler == DIV_MAX, clear it and go to BLANK.
- BLANK: blank counter increments each cycle. When it reaches BLANK_CYCLES-1:
  - clear the counter;
  - set sel = (sel == LAST_INDEX) ? 0 : sel+1;
  - pulse frame_done on the wrap;
  - go to SCAN.
- run = 0 in any state: go to IDLE on the next edge and disable the decoder. sel holds its value.
- Counter width rule: the prescaler compares with ==, so it never exceeds DIV_MAX and never wraps in its own width.
- Reset asserted mid-operation: return to reset values immediately, regardless of clk.

## Timing
- Select slot = DIV_MAX+1+BLANK_CYCLES cycles. With defaults: 4 enabled + 1 blank = 5 cycles.
- Frame = (LAST_INDEX+1) × slot. With defaults: 40 cycles.
- run rising: g1 = 1 and sel = 0 appear one edge after run is sampled high.
- run falling: enables go inactive one edge after run is sampled low.
- sel never changes while enables are active; it changes only on the BLANK→SCAN edge.
- frame_done goes high on the same edge that sel becomes 0.
- run = 0 and step = 1 in the same cycle as a BLANK completion: run wins. No increment, go to IDLE.

## Configuration
- SCAN_STEP_EN defined:
  - The step port exists.
  - In IDLE, enables are active so the decoder shows sel.
  - Each step pulse advances sel with the same wrap rule and frame_done pulse.
  - step is ignored while run = 1.
- SCAN_STEP_EN undefined:
  - No step port.
  - IDLE keeps the decoder disabled.

## Structure
- Shared package holds:
  - the state typedef (IDLE, SCAN, BLANK), encoded as 2-bit constants;
  - the constant SEL_W = 3;
  - the decoder enable-active and enable-inactive triples as named constants.
- One natural sub-module, scan_prescaler: a parameterised count-to-DIV_MAX counter with clear and terminal-count output. The BLANK counter reuses it.

## Test plan
- Reset with run = 1, release: sel = 0; g1/g2a_n/g2b_n = 0/1/1 in the first cycle, then 1/0/0 on the next edge; first sel change to 1 occurs 5 cycles after SCAN entry.
- Free run with defaults for 40 cycles: sel sequence 0..7 each with 4 enabled cycles and 1 blank cycle; exactly one frame_done, coincident with sel returning to 0.
- LAST_INDEX = 2, DIV_MAX = 0, BLANK_CYCLES = 2: sel cycles 0,1,2,0 with 3-cycle slots; frame_done every 9 cycles.
- Drop run during SCAN with sel = 5: next edge enables go inactive and sel stays 5; raise run: SCAN restarts at sel = 0.
- Assert rst asynchronously mid-BLANK: outputs reach reset values without a clock edge.
- With SCAN_STEP_EN, run = 0, seven step pulses from sel = 0: sel = 7 with enables active; an eighth pulse gives sel = 0 and one frame_done.

Source files
------------

// File: rtl/decoder_scan_driver_pkg.sv
// Shared types and constants for the 3-to-8 decoder scan driver.
package decoder_scan_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SCAN  = 2'b01,
    ST_BLANK = 2'b10
  } state_t;

  localparam int unsigned SEL_W = 3;

  // Enable triples ordered {G, G_2A_n, G_2B_n}
  localparam logic [2:0] EN_ACTIVE   = 3'b100;
  localparam logic [2:0] EN_INACTIVE = 3'b011;

  function automatic logic [SEL_W-1:0] sel_advance(input logic [SEL_W-1:0] s,
                                                   input logic [SEL_W-1:0] last);
    return (s == last) ? '0 : s + 1'b1;
  endfunction

endpackage

// File: rtl/decoder_scan_driver_scan_prescaler.sv
// Count-to-MAX counter with synchronous clear and terminal-count flag.
module scan_prescaler #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned MAX   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= (r_count == MAX_V) ? '0 : r_count + 1'b1;
    end
  end

  assign o_tc = i_en && (r_count == MAX_V);

endmodule

// File: rtl/decoder_scan_driver.sv
// Scan select generator for a 74x138-style decoder with dwell and blanking.
// Optional SCAN_STEP_EN adds a step input for manual advance while idle.
module decoder_scan_driver
  import decoder_scan_driver_pkg::*;
#(
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned DIV_MAX      = 3,
  parameter int unsigned BLANK_CYCLES = 1,
  parameter int unsigned LAST_INDEX   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
`ifdef SCAN_STEP_EN
  input  logic             step,
`endif
  output logic [SEL_W-1:0] sel,
  output logic             g1,
  output logic             g2a_n,
  output logic             g2b_n,
  output logic             frame_done
);

  localparam logic [SEL_W-1:0] LAST_V = SEL_W'(LAST_INDEX);

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [2:0]       r_en;
  logic             r_fd;

  state_t           w_next_state;
  logic [SEL_W-1:0] w_next_sel;
  logic [2:0]       w_next_en;
  logic             w_next_fd;
  logic             w_pre_clr;
  logic             w_pre_tc;
  logic             w_blk_clr;
  logic             w_blk_tc;

  scan_prescaler #(
    .WIDTH (DIV_WIDTH),
    .MAX   (DIV_MAX)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_pre_clr),
    .i_en  (r_state == ST_SCAN),
    .o_tc  (w_pre_tc)
  );

  scan_prescaler #(
    .WIDTH (4),
    .MAX   (BLANK_CYCLES - 1)
  ) u_blank (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_blk_clr),
    .i_en  (r_state == ST_BLANK),
    .o_tc  (w_blk_tc)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_sel   = r_sel;
    w_next_fd    = 1'b0;
    w_pre_clr    = 1'b1;
    w_blk_clr    = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_next_state = ST_SCAN;
          w_next_sel   = '0;
        end
`ifdef SCAN_STEP_EN
        else if (step) begin
          w_next_sel = sel_advance(r_sel, LAST_V);
          w_next_fd  = (r_sel == LAST_V);
        end
`endif
      end
      ST_SCAN: begin
        if (!run) begin
          w_next_state = ST_IDLE;
        end else begin
          w_pre_clr = w_pre_tc;
          if (w_pre_tc) w_next_state = ST_BLANK;
        end
      end
      ST_BLANK: begin
        // run low takes priority over a completing gap: sel must not advance
        if (!run) begin
          w_next_state = ST_IDLE;
        end else begin
          w_blk_clr = w_blk_tc;
          if (w_blk_tc) begin
            w_next_state = ST_SCAN;
            w_next_sel   = sel_advance(r_sel, LAST_V);
            w_next_fd    = (r_sel == LAST_V);
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase

`ifdef SCAN_STEP_EN
    w_next_en = (w_next_state == ST_BLANK) ? EN_INACTIVE : EN_ACTIVE;
`else
    w_next_en = (w_next_state == ST_SCAN) ? EN_ACTIVE : EN_INACTIVE;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_en    <= EN_INACTIVE;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_sel   <= w_next_sel;
      r_en    <= w_next_en;
      r_fd    <= w_next_fd;
    end
  end

  assign sel                 = r_sel;
  assign {g1, g2a_n, g2b_n}  = r_en;
  assign frame_done          = r_fd;

endmodule

// File: tb/tb_decoder_scan_driver.sv
// Directed self-checking bench: default-parameter instance A, short-slot instance B.
module tb_decoder_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_a = 1'b0;
  logic       run_b = 1'b0;
`ifdef SCAN_STEP_EN
  logic       step_a = 1'b0;
  logic       step_b = 1'b0;
`endif
  logic [2:0] sel_a, sel_b;
  logic       g1_a, g2a_n_a, g2b_n_a, fd_a;
  logic       g1_b, g2a_n_b, g2b_n_b, fd_b;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] ACT   = 3'b100;
  localparam logic [2:0] INACT = 3'b011;
`ifdef SCAN_STEP_EN
  localparam logic [2:0] IDLE_EN = ACT;
`else
  localparam logic [2:0] IDLE_EN = INACT;
`endif

  always #5 clk = ~clk;

  decoder_scan_driver u_a (
    .clk        (clk),
    .rst        (rst),
    .run        (run_a),
`ifdef SCAN_STEP_EN
    .step       (step_a),
`endif
    .sel        (sel_a),
    .g1         (g1_a),
    .g2a_n      (g2a_n_a),
    .g2b_n      (g2b_n_a),
    .frame_done (fd_a)
  );

  decoder_scan_driver #(
    .DIV_MAX      (0),
    .BLANK_CYCLES (2),
    .LAST_INDEX   (2)
  ) u_b (
    .clk        (clk),
    .rst        (rst),
    .run        (run_b),
`ifdef SCAN_STEP_EN
    .step       (step_b),
`endif
    .sel        (sel_b),
    .g1         (g1_b),
    .g2a_n      (g2a_n_b),
    .g2b_n      (g2b_n_b),
    .frame_done (fd_b)
  );

  function automatic logic [6:0] obs_a();
    return {sel_a, g1_a, g2a_n_a, g2b_n_a, fd_a};
  endfunction

  function automatic logic [6:0] obs_b();
    return {sel_b, g1_b, g2a_n_b, g2b_n_b, fd_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    rst   = 1'b1;
    run_a = 1'b1;
    tick();
    tick();
    exp = {3'd0, INACT, 1'b0};
    checks++;
    if (obs_a() !== exp) begin
      errors++;
      $display("FAIL reset_a: got %b expected %b", obs_a(), exp);
    end
    checks++;
    if (obs_b() !== exp) begin
      errors++;
      $display("FAIL reset_b: got %b expected %b", obs_b(), exp);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (obs_a() !== exp) begin
      errors++;
      $display("FAIL release_first_cycle: got %b expected %b", obs_a(), exp);
    end
    tick();
    exp = {3'd0, ACT, 1'b0};
    checks++;
    if (obs_a() !== exp) begin
      errors++;
      $display("FAIL scan_entry: got %b expected %b", obs_a(), exp);
    end
  endtask

  // Continues from SCAN entry (k = 0): slot of 4 enabled + 1 blank, 8 selects
  task automatic test_free_run();
    logic [6:0] exp;
    logic [2:0] s;
    int         fd_count = 0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      s   = 3'((k / 5) % 8);
      exp = {s, ((k % 5) < 4) ? ACT : INACT, (k % 40) == 0};
      if (k <= 40 && fd_a === 1'b1) fd_count++;
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL free_run k=%0d: got %b expected %b", k, obs_a(), exp);
      end
    end
    checks++;
    if (fd_count != 1) begin
      errors++;
      $display("FAIL frame_done_count: got %0d expected 1", fd_count);
    end
  endtask

  // Slot of 1 enabled + 2 blank, selects 0..2
  task automatic test_short_config();
    logic [6:0] exp;
    logic [2:0] s;
    int         fd_count = 0;
    run_b = 1'b1;
    for (int k = 0; k <= 19; k++) begin
      tick();
      s   = 3'((k / 3) % 3);
      exp = {s, ((k % 3) == 0) ? ACT : INACT, (k > 0) && ((k % 9) == 0)};
      if (k >= 1 && k <= 18 && fd_b === 1'b1) fd_count++;
      checks++;
      if (obs_b() !== exp) begin
        errors++;
        $display("FAIL short_cfg k=%0d: got %b expected %b", k, obs_b(), exp);
      end
    end
    checks++;
    if (fd_count != 2) begin
      errors++;
      $display("FAIL short_frame_count: got %0d expected 2", fd_count);
    end
    run_b = 1'b0;
  endtask

  task automatic test_run_drop();
    logic [6:0] exp;
    run_a = 1'b0;
    tick();
    tick();
    run_a = 1'b1;
    for (int k = 0; k <= 26; k++) tick();
    exp = {3'd5, ACT, 1'b0};
    checks++;
    if (obs_a() !== exp) begin
      errors++;
      $display("FAIL pre_drop: got %b expected %b", obs_a(), exp);
    end
    run_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = {3'd5, IDLE_EN, 1'b0};
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL run_drop cyc=%0d: got %b expected %b", i, obs_a(), exp);
      end
    end
    run_a = 1'b1;
    tick();
    exp = {3'd0, ACT, 1'b0};
    checks++;
    if (obs_a() !== exp) begin
      errors++;
      $display("FAIL run_restart: got %b expected %b", obs_a(), exp);
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] exp;
    for (int k = 1; k <= 9; k++) tick();
    exp = {3'd1, INACT, 1'b0};
    checks++;
    if (obs_a() !== exp) begin
      errors++;
      $display("FAIL mid_blank: got %b expected %b", obs_a(), exp);
    end
    #2;
    rst = 1'b1;
    #1;
    exp = {3'd0, INACT, 1'b0};
    checks++;
    if (obs_a() !== exp) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", obs_a(), exp);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    exp = {3'd0, ACT, 1'b0};
    checks++;
    if (obs_a() !== exp) begin
      errors++;
      $display("FAIL post_reset_entry: got %b expected %b", obs_a(), exp);
    end
  endtask

`ifdef SCAN_STEP_EN
  task automatic test_step();
    logic [6:0] exp;
    run_a = 1'b0;
    tick();
    exp = {3'd0, ACT, 1'b0};
    checks++;
    if (obs_a() !== exp) begin
      errors++;
      $display("FAIL step_idle: got %b expected %b", obs_a(), exp);
    end
    for (int i = 1; i <= 8; i++) begin
      step_a = 1'b1;
      tick();
      step_a = 1'b0;
      exp = {3'(i % 8), ACT, i == 8};
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL step i=%0d: got %b expected %b", i, obs_a(), exp);
      end
    end
    tick();
    exp = {3'd0, ACT, 1'b0};
    checks++;
    if (obs_a() !== exp) begin
      errors++;
      $display("FAIL step_fd_clear: got %b expected %b", obs_a(), exp);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_short_config();
    test_run_drop();
    test_async_reset();
`ifdef SCAN_STEP_EN
    test_step();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
